gbf_nbank_ctrl: RTL and testbench

GBF_NBANK_CTRL -- requirements
Module: gbf_nbank_ctrl

---
 rtl/gbf_nbank_if.sv | 38 +++
 rtl/gbf_nbank_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_gbf_nbank_ctrl.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/gbf_nbank_if.sv
// GBF bank controller bus bundle: start/config, producer ready,
// RF request/write side and GBF port-b read side.
interface gbf_nbank_if #(
   parameter int NUM_BANK          = 2,
   parameter int GBF_ADDR_BITWIDTH = 5,
   parameter int RF_ADDR_BITWIDTH  = 2,
   parameter int REUSE_BITWIDTH    = 4,
   parameter int BANK_W            = $clog2(NUM_BANK)
);
   logic                         gbf_data_avail;
   logic [GBF_ADDR_BITWIDTH:0]   cfg_lines;
   logic [REUSE_BITWIDTH-1:0]    cfg_reuse;
   logic [NUM_BANK-1:0]          buf_ready;
   logic                         rf_need_data;
   logic                         finish;
   logic [NUM_BANK-1:0]          en_b;
   logic [GBF_ADDR_BITWIDTH-1:0] addr_b;
   logic                         rf_we;
   logic [RF_ADDR_BITWIDTH-1:0]  rf_w_addr;
   logic                         rf_send_finish;
   logic [NUM_BANK-1:0]          gbf_need_data;
   logic [BANK_W-1:0]            cur_bank;
   logic                         done;

   modport master (
      output gbf_data_avail, cfg_lines, cfg_reuse, buf_ready,
      output rf_need_data, finish,
      input  en_b, addr_b, rf_we, rf_w_addr, rf_send_finish,
      input  gbf_need_data, cur_bank, done
   );

   modport slave (
      input  gbf_data_avail, cfg_lines, cfg_reuse, buf_ready,
      input  rf_need_data, finish,
      output en_b, addr_b, rf_we, rf_w_addr, rf_send_finish,
      output gbf_need_data, cur_bank, done
   );
endinterface

// File: rtl/gbf_nbank_ctrl.sv
// Rotating N-bank GBF read controller: streams RF-sized chunks
// out of the current bank, reuses it cfg_reuse times, then releases it.
module gbf_nbank_ctrl #(
   parameter int NUM_BANK          = 2,
   parameter int GBF_ADDR_BITWIDTH = 5,
   parameter int GBF_DEPTH         = 32,
   parameter int RF_ADDR_BITWIDTH  = 2,
   parameter int RF_DEPTH          = 4,
   parameter int REUSE_BITWIDTH    = 4
) (
   input  logic       clk,
   input  logic       reset,
   gbf_nbank_if.slave bus
);
   localparam int BANK_W = $clog2(NUM_BANK);
   localparam int LINE_W = GBF_ADDR_BITWIDTH + 1;
   localparam int CNT_W  = RF_ADDR_BITWIDTH;

   localparam logic [LINE_W-1:0] DEPTH_L = LINE_W'(GBF_DEPTH);
   localparam logic [LINE_W-1:0] RF_L    = LINE_W'(RF_DEPTH);
   localparam logic [CNT_W-1:0]  LAST    = CNT_W'(RF_DEPTH - 1);
   localparam logic [BANK_W-1:0] TOP     = BANK_W'(NUM_BANK - 1);

   typedef enum logic [2:0] {
      IDLE, WAIT_BANK, WAIT_REQ, STREAM, RELEASE
   } state_t;

   state_t                       state_q, state_d;
   logic [BANK_W-1:0]            cur_bank_q, cur_bank_d;
   logic [LINE_W-1:0]            offset_q, offset_d;
   logic [REUSE_BITWIDTH-1:0]    pass_q, pass_d;
   logic [CNT_W-1:0]             cnt_q, cnt_d;
   logic [LINE_W-1:0]            lines_q, lines_d;
   logic [REUSE_BITWIDTH-1:0]    reuse_q, reuse_d;
   logic [NUM_BANK-1:0]          valid_q, valid_d;
   logic [NUM_BANK-1:0]          en_b_q, en_b_d;
   logic [GBF_ADDR_BITWIDTH-1:0] addr_b_q, addr_b_d;
   logic                         rf_we_q, rf_we_d;
   logic [CNT_W-1:0]             rf_w_addr_q, rf_w_addr_d;
   logic                         sf_q, sf_d;
   logic [NUM_BANK-1:0]          need_q, need_d;
   logic                         done_q, done_d;

   logic [LINE_W-1:0]            lines_raw, lines_rnd, lines_norm;
   logic [REUSE_BITWIDTH-1:0]    reuse_norm, pass_inc;
   logic [LINE_W-1:0]            off_inc;
   logic [NUM_BANK-1:0]          ready_now, rel_mask, bank_oh;
   logic                         abort;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cur_bank_q  <= '0;
         offset_q    <= '0;
         pass_q      <= '0;
         cnt_q       <= '0;
         lines_q     <= DEPTH_L;
         reuse_q     <= REUSE_BITWIDTH'(1);
         valid_q     <= '0;
         en_b_q      <= '0;
         addr_b_q    <= '0;
         rf_we_q     <= 1'b0;
         rf_w_addr_q <= '0;
         sf_q        <= 1'b0;
         need_q      <= '1;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cur_bank_q  <= cur_bank_d;
         offset_q    <= offset_d;
         pass_q      <= pass_d;
         cnt_q       <= cnt_d;
         lines_q     <= lines_d;
         reuse_q     <= reuse_d;
         valid_q     <= valid_d;
         en_b_q      <= en_b_d;
         addr_b_q    <= addr_b_d;
         rf_we_q     <= rf_we_d;
         rf_w_addr_q <= rf_w_addr_d;
         sf_q        <= sf_d;
         need_q      <= need_d;
         done_q      <= done_d;
      end
   end

   // Line count: 0 or oversize means a full bank, then floor to RF_DEPTH.
   always_comb begin
      lines_raw = bus.cfg_lines;
      if (bus.cfg_lines == '0 || bus.cfg_lines > DEPTH_L)
         lines_raw = DEPTH_L;
      lines_rnd  = lines_raw - (lines_raw % RF_L);
      lines_norm = (lines_rnd == '0) ? DEPTH_L : lines_rnd;
      reuse_norm = (bus.cfg_reuse == '0) ? REUSE_BITWIDTH'(1)
                                         : bus.cfg_reuse;
   end

   always_comb begin
      state_d    = state_q;
      cur_bank_d = cur_bank_q;
      offset_d   = offset_q;
      pass_d     = pass_q;
      cnt_d      = cnt_q;
      lines_d    = lines_q;
      reuse_d    = reuse_q;
      rel_mask   = '0;
      bank_oh    = '0;
      bank_oh[cur_bank_q] = 1'b1;
      ready_now  = valid_q | bus.buf_ready;
      off_inc    = offset_q + RF_L;
      pass_inc   = pass_q + REUSE_BITWIDTH'(1);
      abort      = bus.finish && (state_q != IDLE);

      unique case (state_q)
         IDLE: begin
            if (bus.gbf_data_avail) begin
               lines_d = lines_norm;
               reuse_d = reuse_norm;
               state_d = WAIT_BANK;
            end
         end
         WAIT_BANK: begin
            if (ready_now[cur_bank_q])
               state_d = WAIT_REQ;
         end
         WAIT_REQ: begin
            if (bus.rf_need_data) begin
               cnt_d   = '0;
               state_d = STREAM;
            end
         end
         STREAM: begin
            if (cnt_q != LAST) begin
               cnt_d = cnt_q + CNT_W'(1);
            end else begin
               state_d = WAIT_REQ;
               if (off_inc >= lines_q) begin
                  offset_d = '0;
                  pass_d   = pass_inc;
                  if (pass_inc == reuse_q)
                     state_d = RELEASE;
               end else begin
                  offset_d = off_inc;
               end
            end
         end
         RELEASE: begin
            rel_mask[cur_bank_q] = 1'b1;
            cur_bank_d = (cur_bank_q == TOP) ? '0
                       : cur_bank_q + BANK_W'(1);
            pass_d  = '0;
            state_d = WAIT_BANK;
         end
         default: state_d = IDLE;
      endcase

      // A release wins over a same-cycle refill of that bank.
      valid_d = (valid_q | bus.buf_ready) & ~rel_mask;

      if (abort) begin
         state_d    = IDLE;
         valid_d    = '0;
         offset_d   = '0;
         pass_d     = '0;
         cnt_d      = '0;
         cur_bank_d = '0;
      end

      en_b_d   = '0;
      addr_b_d = addr_b_q;
      if (state_d == STREAM) begin
         en_b_d   = bank_oh;
         addr_b_d = offset_q[GBF_ADDR_BITWIDTH-1:0]
                  + GBF_ADDR_BITWIDTH'(cnt_d);
      end

      // BRAM data lands one cycle after the read enable.
      rf_we_d     = (state_q == STREAM) && !abort;
      rf_w_addr_d = (state_q == STREAM) ? cnt_q : rf_w_addr_q;
      sf_d        = (state_q == STREAM) && (cnt_q == LAST) && !abort;
      done_d      = abort;
      need_d      = ~valid_d;
   end

   assign bus.en_b           = en_b_q;
   assign bus.addr_b         = addr_b_q;
   assign bus.rf_we          = rf_we_q;
   assign bus.rf_w_addr      = rf_w_addr_q;
   assign bus.rf_send_finish = sf_q;
   assign bus.gbf_need_data  = need_q;
   assign bus.cur_bank       = cur_bank_q;
   assign bus.done           = done_q;
endmodule

// File: tb/tb_gbf_nbank_ctrl.sv
// Directed bench for gbf_nbank_ctrl: a 2-bank and a 4-bank instance
// share the stimulus, selected by sel; unselected DUT sees idle inputs.
module tb_gbf_nbank_ctrl;
   logic       clk = 1'b0;
   logic       reset;
   logic       sel;
   logic       avail, need, fin;
   logic [5:0] lines;
   logic [3:0] reuse;
   logic [3:0] bready;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   gbf_nbank_if #(.NUM_BANK(2)) i2 ();
   gbf_nbank_if #(.NUM_BANK(4)) i4 ();

   gbf_nbank_ctrl #(.NUM_BANK(2)) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (i2)
   );

   gbf_nbank_ctrl #(.NUM_BANK(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (i4)
   );

   assign i2.gbf_data_avail = avail & ~sel;
   assign i2.cfg_lines      = lines;
   assign i2.cfg_reuse      = reuse;
   assign i2.buf_ready      = sel ? 2'b00 : bready[1:0];
   assign i2.rf_need_data   = need & ~sel;
   assign i2.finish         = fin & ~sel;

   assign i4.gbf_data_avail = avail & sel;
   assign i4.cfg_lines      = lines;
   assign i4.cfg_reuse      = reuse;
   assign i4.buf_ready      = sel ? bready : 4'b0000;
   assign i4.rf_need_data   = need & sel;
   assign i4.finish         = fin & sel;

   logic [3:0] o_en_b, o_need;
   logic [4:0] o_addr;
   logic [1:0] o_waddr, o_bank;
   logic       o_we, o_sf, o_done;

   assign o_en_b  = sel ? i4.en_b : {2'b00, i2.en_b};
   assign o_addr  = sel ? i4.addr_b : i2.addr_b;
   assign o_we    = sel ? i4.rf_we : i2.rf_we;
   assign o_waddr = sel ? i4.rf_w_addr : i2.rf_w_addr;
   assign o_sf    = sel ? i4.rf_send_finish : i2.rf_send_finish;
   assign o_need  = sel ? i4.gbf_need_data : {2'b00, i2.gbf_need_data};
   assign o_bank  = sel ? i4.cur_bank : {1'b0, i2.cur_bank};
   assign o_done  = sel ? i4.done : i2.done;

   task automatic check(input string tag, input logic [31:0] act,
                        input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_outs(input string tag, input logic [3:0] nd);
      check({tag, ".en_b"}, o_en_b, 0);
      check({tag, ".addr_b"}, o_addr, 0);
      check({tag, ".rf_we"}, o_we, 0);
      check({tag, ".rf_w_addr"}, o_waddr, 0);
      check({tag, ".send_fin"}, o_sf, 0);
      check({tag, ".done"}, o_done, 0);
      check({tag, ".need"}, o_need, nd);
      check({tag, ".bank"}, o_bank, 0);
   endtask

   task automatic do_reset();
      logic [3:0] nd;
      nd     = sel ? 4'hF : 4'h3;
      avail  = 0;
      need   = 0;
      fin    = 0;
      bready = 0;
      reset  = 1;
      tick();
      tick();
      idle_outs("in_rst", nd);
      reset = 0;
      tick();
      idle_outs("post_rst", nd);
   endtask

   task automatic start(input int l, input int r, input logic [3:0] br);
      lines  = 6'(l);
      reuse  = 4'(r);
      avail  = 1;
      bready = br;
      tick();
      avail  = 0;
      bready = 0;
   endtask

   task automatic wait_en();
      need = 1;
      for (int t = 0; t < 30 && o_en_b == 0; t++) tick();
      need = 0;
      check("chunk_start", 32'(o_en_b != 0), 1);
   endtask

   task automatic chunk(input int bank, input int base);
      wait_en();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) tick();
         check("en_b", o_en_b, 1 << bank);
         check("addr_b", o_addr, base + i);
         check("send_fin_mid", o_sf, 0);
         if (i > 0) begin
            check("rf_we", o_we, 1);
            check("rf_w_addr", o_waddr, i - 1);
         end
      end
      tick();
      check("en_b_end", o_en_b, 0);
      check("rf_we_last", o_we, 1);
      check("rf_w_addr_last", o_waddr, 3);
      check("send_fin", o_sf, 1);
   endtask

   initial begin
      sel    = 0;
      lines  = 0;
      reuse  = 0;
      do_reset();

      // two chunks of an 8-line bank, single pass
      start(8, 1, 4'b0001);
      check("need_b0_filled", o_need, 4'b0010);
      chunk(0, 0);
      check("need_mid", o_need, 4'b0010);
      chunk(0, 4);
      tick();
      check("need_after_rel", o_need, 4'b0011);
      check("bank_after_rel", o_bank, 1);

      // bank1 empty: must stall with no read enable
      need = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_en_b", o_en_b, 0);
      end
      bready = 4'b0010;
      tick();
      bready = 0;
      check("need_b1_filled", o_need, 4'b0001);
      chunk(1, 0);

      // abort on the second stream cycle
      wait_en();
      check("abort_beat0", o_addr, 4);
      tick();
      check("abort_beat1", o_en_b, 4'b0010);
      fin = 1;
      tick();
      fin = 0;
      check("abort_en_b", o_en_b, 0);
      check("abort_rf_we", o_we, 0);
      check("abort_done", o_done, 1);
      check("abort_need", o_need, 4'b0011);
      tick();
      check("abort_done_pulse", o_done, 0);
      check("abort_rf_we2", o_we, 0);

      // 4-line bank reused three times
      start(4, 3, 4'b0001);
      for (int p = 0; p < 3; p++) begin
         chunk(0, 0);
         if (p < 2) check("reuse_hold", o_need, 4'b0010);
      end
      tick();
      check("reuse_need", o_need, 4'b0011);
      check("reuse_bank", o_bank, 1);

      // reset in the middle of a stream
      do_reset();
      start(8, 1, 4'b0001);
      wait_en();
      tick();
      reset = 1;
      tick();
      check("rst_mid_en_b", o_en_b, 0);
      check("rst_mid_rf_we", o_we, 0);
      check("rst_mid_need", o_need, 4'b0011);
      tick();
      check("rst_mid_rf_we2", o_we, 0);
      reset = 0;
      tick();

      // zero config: full 32-line bank, one pass
      start(0, 0, 4'b0001);
      for (int c = 0; c < 8; c++) chunk(0, 4 * c);
      tick();
      check("full_need", o_need, 4'b0011);
      check("full_bank", o_bank, 1);

      // 6 lines floors to one 4-line chunk
      do_reset();
      start(6, 1, 4'b0001);
      chunk(0, 0);
      tick();
      check("round_bank", o_bank, 1);

      // 4-bank rotation with wrap
      sel = 1;
      do_reset();
      start(4, 1, 4'b1111);
      check("rot_need0", o_need, 4'b0000);
      for (int k = 0; k < 4; k++) begin
         chunk(k, 0);
         if (k == 3) bready = 4'b1000;
         tick();
         bready = 0;
         check("rot_bank", o_bank, (k + 1) % 4);
      end
      check("rot_need_all", o_need, 4'b1111);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end
endmodule
